// File: rtl/nios2_pio_in_edge.sv
`default_nettype none
// ============================================================================
//  Module   : nios2_pio_in_edge
//  Purpose  : Avalon-MM input PIO for the Nios II data master. Board-level
//             status inputs pass through a synchroniser chain and an
//             optional per-bit debounce filter. Edges on the filtered value
//             are captured into a write-1-to-clear register. A masked
//             level interrupt is raised from the captured edges.
//  Revision : 1.0  initial release
// ----------------------------------------------------------------------------
//  Parameters
//    WIDTH            number of input bits, 1..32
//    SYNC_STAGES      synchroniser flops on in_port, 2..4
//    DEBOUNCE_CYCLES  stable cycles before a filtered bit follows its input
//                     (0 = filter bypassed), up to 65535
//    EDGE_TYPE        0 = rising, 1 = falling, 2 = any edge
//  Ports
//    clk         in   system clock, single domain
//    reset_n     in   asynchronous active-low reset
//    address     in   [1:0]  word address: 0 DATA, 1 IRQMASK, 2 reserved,
//                            3 EDGECAPTURE
//    chipselect  in   slave select
//    write_n     in   active-low write strobe, qualified by chipselect
//    writedata   in   [31:0] write data, bits [WIDTH-1:0] used
//    in_port     in   [WIDTH-1:0] asynchronous external inputs
//    readdata    out  [31:0] registered read data, zero-extended
//    irq         out  level interrupt, |(edgecapture & irqmask)
// ============================================================================
module nios2_pio_in_edge #(
   parameter int WIDTH           = 2,
   parameter int SYNC_STAGES     = 2,
   parameter int DEBOUNCE_CYCLES = 0,
   parameter int EDGE_TYPE       = 0
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic [1:0]        address,
   input  logic              chipselect,
   input  logic              write_n,
   input  logic [31:0]       writedata,
   input  logic [WIDTH-1:0]  in_port,
   output logic [31:0]       readdata,
   output logic              irq
);

   // -------------------------------------------------------------------------
   // Register map
   // -------------------------------------------------------------------------
   localparam logic [1:0] C_ADDR_DATA = 2'd0;
   localparam logic [1:0] C_ADDR_MASK = 2'd1;
   localparam logic [1:0] C_ADDR_EDGE = 2'd3;

   // -------------------------------------------------------------------------
   // Synchroniser chain: stage 0 samples the pins, last stage feeds the filter
   // -------------------------------------------------------------------------
   logic [SYNC_STAGES-1:0][WIDTH-1:0] sync_q;
   logic [SYNC_STAGES-1:0][WIDTH-1:0] sync_d;
   logic [WIDTH-1:0]                  sync_out;

   always_comb begin
      sync_d = {sync_q[SYNC_STAGES-2:0], in_port};
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         sync_q <= '0;
      end else begin
         sync_q <= sync_d;
      end
   end

   assign sync_out = sync_q[SYNC_STAGES-1];

   // -------------------------------------------------------------------------
   // Debounce filter
   // -------------------------------------------------------------------------
   logic [WIDTH-1:0] filt;

   generate
      if (DEBOUNCE_CYCLES == 0) begin : g_bypass
         assign filt = sync_out;
      end else begin : g_debounce
         localparam logic [15:0] C_CNT_LAST = 16'(DEBOUNCE_CYCLES - 1);

         logic [WIDTH-1:0][15:0] cnt_q;
         logic [WIDTH-1:0][15:0] cnt_d;
         logic [WIDTH-1:0]       filt_q;
         logic [WIDTH-1:0]       filt_d;

         // Each bit counts consecutive cycles of disagreement between the
         // synchronised input and the filtered value; any agreement restarts
         // the count, so only an uninterrupted run of DEBOUNCE_CYCLES flips it.
         always_comb begin
            cnt_d  = cnt_q;
            filt_d = filt_q;
            for (int i = 0; i < WIDTH; i++) begin
               if (sync_out[i] == filt_q[i]) begin
                  cnt_d[i] = '0;
               end else if (cnt_q[i] == C_CNT_LAST) begin
                  filt_d[i] = sync_out[i];
                  cnt_d[i]  = '0;
               end else begin
                  cnt_d[i] = cnt_q[i] + 16'd1;
               end
            end
         end

         always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
               cnt_q  <= '0;
               filt_q <= '0;
            end else begin
               cnt_q  <= cnt_d;
               filt_q <= filt_d;
            end
         end

         assign filt = filt_q;
      end
   endgenerate

   // -------------------------------------------------------------------------
   // Edge detection on the filtered value
   // -------------------------------------------------------------------------
   logic [WIDTH-1:0] prev_q;
   logic [WIDTH-1:0] prev_d;
   logic [WIDTH-1:0] rise;
   logic [WIDTH-1:0] fall;
   logic [WIDTH-1:0] edge_det;

   always_comb begin
      prev_d = filt;
      rise   = filt & ~prev_q;
      fall   = ~filt & prev_q;
      case (EDGE_TYPE)
         0:       edge_det = rise;
         1:       edge_det = fall;
         default: edge_det = rise | fall;
      endcase
   end

   // -------------------------------------------------------------------------
   // Bus write decode, capture and mask registers
   // -------------------------------------------------------------------------
   logic             wr_en;
   logic [WIDTH-1:0] clr;
   logic [WIDTH-1:0] cap_q;
   logic [WIDTH-1:0] cap_d;
   logic [WIDTH-1:0] irqmask_q;
   logic [WIDTH-1:0] irqmask_d;

   always_comb begin
      wr_en     = chipselect & ~write_n;
      clr       = '0;
      irqmask_d = irqmask_q;
      if (wr_en && (address == C_ADDR_EDGE)) begin
         clr = writedata[WIDTH-1:0];
      end
      if (wr_en && (address == C_ADDR_MASK)) begin
         irqmask_d = writedata[WIDTH-1:0];
      end
      // OR-ing the new edges after the clear makes a same-cycle set win.
      cap_d = (cap_q & ~clr) | edge_det;
   end

   // -------------------------------------------------------------------------
   // Read mux: registered every cycle, independent of chipselect
   // -------------------------------------------------------------------------
   logic [31:0] readdata_q;
   logic [31:0] readdata_d;

   always_comb begin
      readdata_d = '0;
      case (address)
         C_ADDR_DATA: readdata_d[WIDTH-1:0] = filt;
         C_ADDR_MASK: readdata_d[WIDTH-1:0] = irqmask_q;
         C_ADDR_EDGE: readdata_d[WIDTH-1:0] = cap_q;
         default:     readdata_d = '0;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         prev_q     <= '0;
         cap_q      <= '0;
         irqmask_q  <= '0;
         readdata_q <= '0;
      end else begin
         prev_q     <= prev_d;
         cap_q      <= cap_d;
         irqmask_q  <= irqmask_d;
         readdata_q <= readdata_d;
      end
   end

   assign readdata = readdata_q;

   // Decoded purely from flops, so no bus input reaches irq in the same cycle.
   assign irq = |(cap_q & irqmask_q);

   // Upper write-data bits are not stored when WIDTH < 32.
   logic unused_wdata;
   assign unused_wdata = ^writedata;

endmodule
`default_nettype wire

// File: tb/tb_nios2_pio_in_edge.sv
`default_nettype none
// ============================================================================
//  Module   : tb_nios2_pio_in_edge
//  Purpose  : Self-checking bench for nios2_pio_in_edge. Two instances:
//             A: WIDTH=8, SYNC_STAGES=2, no debounce, any-edge capture
//             B: WIDTH=2, SYNC_STAGES=3, DEBOUNCE_CYCLES=4, rising capture
//             A reference model derived from the register rules is stepped
//             every clock and compared against both instances.
//  Revision : 1.0  initial release
// ============================================================================
module tb_nios2_pio_in_edge;

   logic        clk        = 1'b0;
   logic        reset_n    = 1'b0;
   logic [1:0]  address    = 2'd0;
   logic        chipselect = 1'b0;
   logic        write_n    = 1'b1;
   logic [31:0] writedata  = 32'd0;
   logic [7:0]  in_port    = 8'd0;
   logic [31:0] rd_a, rd_b;
   logic        irq_a, irq_b;

   int n_cmp = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   nios2_pio_in_edge #(
      .WIDTH(8), .SYNC_STAGES(2), .DEBOUNCE_CYCLES(0), .EDGE_TYPE(2)
   ) u_a (
      .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
      .write_n(write_n), .writedata(writedata), .in_port(in_port),
      .readdata(rd_a), .irq(irq_a)
   );

   nios2_pio_in_edge #(
      .WIDTH(2), .SYNC_STAGES(3), .DEBOUNCE_CYCLES(4), .EDGE_TYPE(0)
   ) u_b (
      .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
      .write_n(write_n), .writedata(writedata), .in_port(in_port[1:0]),
      .readdata(rd_b), .irq(irq_b)
   );

   // ---------------------------------------------------------------- model
   int ms_w [2] = '{8, 2};
   int ms_s [2] = '{2, 3};
   int ms_d [2] = '{0, 4};
   int ms_e [2] = '{2, 0};

   logic [7:0]  hist  [2][16];   // hist[k][0] = most recent sampled in_port
   logic [7:0]  mfilt [2];
   logic [7:0]  mprev [2];
   logic [7:0]  mcap  [2];
   logic [7:0]  mmask [2];
   logic [31:0] mrd   [2];

   function automatic logic [7:0] wmask(input int k);
      logic [8:0] t;
      t = 9'(1) << ms_w[k];
      return 8'(t - 9'd1);
   endfunction

   task automatic mreset();
      for (int k = 0; k < 2; k++) begin
         for (int j = 0; j < 16; j++) hist[k][j] = 8'h00;
         mfilt[k] = 8'h00; mprev[k] = 8'h00; mcap[k] = 8'h00;
         mmask[k] = 8'h00; mrd[k]   = 32'h0;
      end
   endtask

   // One clock edge: uses the bus/pin values present just before the edge.
   task automatic mstep();
      for (int k = 0; k < 2; k++) begin
         logic [7:0] msk, clr, rise, fall, ev, flips;
         logic       wr;
         msk = wmask(k);
         wr  = chipselect && !write_n;
         case (address)
            2'd0:    mrd[k] = {24'h0, mfilt[k]};
            2'd1:    mrd[k] = {24'h0, mmask[k]};
            2'd2:    mrd[k] = 32'h0;
            default: mrd[k] = {24'h0, mcap[k]};
         endcase
         clr  = (wr && address == 2'd3) ? (writedata[7:0] & msk) : 8'h00;
         rise = mfilt[k] & ~mprev[k];
         fall = ~mfilt[k] & mprev[k] & msk;
         ev   = (ms_e[k] == 0) ? rise : (ms_e[k] == 1) ? fall : (rise | fall);
         mcap[k] = (mcap[k] & ~clr) | ev;
         if (wr && address == 2'd1) mmask[k] = writedata[7:0] & msk;
         mprev[k] = mfilt[k];
         // Debounced bit flips once the last D synchronised values all differ.
         if (ms_d[k] > 0) begin
            flips = msk;
            for (int j = ms_s[k] - 1; j <= ms_s[k] + ms_d[k] - 2; j++)
               flips = flips & (hist[k][j] ^ mfilt[k]);
            mfilt[k] = mfilt[k] ^ flips;
         end
         for (int j = 15; j > 0; j--) hist[k][j] = hist[k][j-1];
         hist[k][0] = in_port & msk;
         if (ms_d[k] == 0) mfilt[k] = hist[k][ms_s[k] - 1];
      end
   endtask

   // ---------------------------------------------------------------- checks
   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
      n_cmp++;
      if (act !== req) begin
         n_err++;
         $display("FAIL %s: actual %h required %h at %0t", nm, act, req, $time);
      end
   endtask

   always @(negedge clk) begin
      chk("cmp_rd_a",  rd_a, mrd[0]);
      chk("cmp_rd_b",  rd_b, mrd[1]);
      chk("cmp_irq_a", {31'd0, irq_a}, {31'd0, |(mcap[0] & mmask[0])});
      chk("cmp_irq_b", {31'd0, irq_b}, {31'd0, |(mcap[1] & mmask[1])});
   end

   // ---------------------------------------------------------------- stimulus
   task automatic cyc();
      @(posedge clk);
      if (!reset_n) mreset();
      else          mstep();
      #1;
   endtask

   task automatic cycn(input int n);
      for (int i = 0; i < n; i++) cyc();
   endtask

   task automatic wr(input logic [1:0] a, input logic [31:0] d);
      chipselect = 1'b1; write_n = 1'b0; address = a; writedata = d;
      cyc();
      chipselect = 1'b0; write_n = 1'b1;
   endtask

   initial begin
      mreset();
      // Reset with inputs high
      in_port = 8'hFF;
      cycn(3);
      reset_n = 1'b1;
      chk("rst_rd_a", rd_a, 32'h0);
      chk("rst_rd_b", rd_b, 32'h0);
      cyc();
      chk("rst_lat_rd_a", rd_a, 32'h0);
      cycn(10);
      chk("rst_data_a", rd_a, 32'hFF);
      chk("rst_data_b", rd_b, 32'h3);
      address = 2'd3;
      cyc();
      chk("rst_cap_a", rd_a, 32'hFF);
      chk("rst_cap_b", rd_b, 32'h3);
      chk("rst_irq_a", {31'd0, irq_a}, 32'd0);

      // Latency: A D=0 S=2, B D=4 S=3
      in_port = 8'h00;
      cycn(12);
      wr(2'd3, 32'hFF);
      wr(2'd1, 32'h01);
      address = 2'd0;
      in_port = 8'h01;
      cyc();                                        // edge k
      cyc();                                        // k+1
      chk("lat_k1_rd_a",  rd_a, 32'h0);
      chk("lat_k1_irq_a", {31'd0, irq_a}, 32'd0);
      cyc();                                        // k+2
      chk("lat_k2_rd_a",  rd_a, 32'h1);
      chk("lat_k2_irq_a", {31'd0, irq_a}, 32'd1);
      cycn(4);                                      // k+6
      chk("lat_k6_rd_b",  rd_b, 32'h0);
      chk("lat_k6_irq_b", {31'd0, irq_b}, 32'd0);
      cyc();                                        // k+7
      chk("lat_k7_rd_b",  rd_b, 32'h1);
      chk("lat_k7_irq_b", {31'd0, irq_b}, 32'd1);

      // Debounce on B: 3-cycle pulse rejected, 6-cycle pulse accepted
      in_port = 8'h00;
      cycn(12);
      wr(2'd3, 32'hFF);
      address = 2'd0;
      in_port = 8'h01; cycn(3); in_port = 8'h00;
      cycn(12);
      chk("deb3_data_b", rd_b, 32'h0);
      address = 2'd3;
      cyc();
      chk("deb3_cap_b", rd_b, 32'h0);
      in_port = 8'h01; cycn(6); in_port = 8'h00;
      cycn(8);
      chk("deb6_cap_b", rd_b, 32'h1);

      // Write-1-to-clear and set/clear collision on A
      cycn(12);
      wr(2'd3, 32'hFF);
      in_port = 8'hA5;
      cycn(5);
      chk("w1c_set_a", rd_a, 32'hA5);
      wr(2'd3, 32'h0000_000F);
      cyc();
      chk("w1c_clr_a", rd_a, 32'hA0);
      in_port = 8'hA7;
      cycn(2);
      wr(2'd3, 32'hFFFF_FF02);                      // upper bits ignored
      cyc();
      chk("w1c_coll_a", rd_a, 32'hA2);

      // Mask and irq on A
      wr(2'd3, 32'hFF);
      in_port = 8'hB7;
      cycn(5);
      address = 2'd3;
      cyc();
      chk("mask_cap_a", rd_a, 32'h10);
      chk("mask_off_irq_a", {31'd0, irq_a}, 32'd0);
      wr(2'd1, 32'h01);
      chk("mask01_irq_a", {31'd0, irq_a}, 32'd0);
      wr(2'd1, 32'h10);
      chk("mask10_irq_a", {31'd0, irq_a}, 32'd1);
      wr(2'd3, 32'h10);
      chk("clr4_irq_a", {31'd0, irq_a}, 32'd0);

      // Reset mid-operation: A cap=FF, B debounce counter at 2
      in_port = 8'h48;
      cycn(5);
      chk("pre_rst_cap_a", rd_a, 32'hFF);
      chk("pre_rst_irq_a", {31'd0, irq_a}, 32'd1);
      #1;
      reset_n = 1'b0;
      mreset();
      #1;
      chk("async_rd_a",  rd_a, 32'h0);
      chk("async_rd_b",  rd_b, 32'h0);
      chk("async_irq_a", {31'd0, irq_a}, 32'd0);
      chk("async_irq_b", {31'd0, irq_b}, 32'd0);
      cycn(2);
      reset_n = 1'b1;
      cycn(12);
      chk("post_rst_cap_a", rd_a, 32'h48);
      chk("post_rst_cap_b", rd_b, 32'h0);

      // Randomised traffic
      for (int i = 0; i < 3000; i++) begin
         chipselect = 1'($urandom_range(0, 1));
         write_n    = 1'($urandom_range(0, 1));
         address    = 2'($urandom_range(0, 3));
         writedata  = $urandom;
         if ($urandom_range(0, 5) == 0) in_port = in_port ^ 8'($urandom);
         if ($urandom_range(0, 499) == 0) begin
            reset_n = 1'b0;
            mreset();
            cyc();
            reset_n = 1'b1;
         end else begin
            cyc();
         end
      end
      chipselect = 1'b0; write_n = 1'b1;
      cycn(2);

      $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
      $finish;
   end

endmodule
`default_nettype wire
